// File: rtl/hazard_unit_if.sv
// Issue-stage bundle between decoder and hazard unit: decoded operand info in, interlock status out.
// The decoder drives the master side; the hazard unit is the slave.
interface hazard_unit_if;
    logic        issue_valid;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_enable;
    logic        rs2_enable;
    logic [4:0]  rd_addr;
    logic        rd_enable;
    logic        is_load;
    logic        use_fpu;
    logic        flush;
    logic        stall;
    logic        issue;
    logic        fpu_busy;
    logic [31:0] pending;

    modport master (
        output issue_valid, rs1_addr, rs2_addr, rs1_enable, rs2_enable,
               rd_addr, rd_enable, is_load, use_fpu, flush,
        input  stall, issue, fpu_busy, pending
    );

    modport slave (
        input  issue_valid, rs1_addr, rs2_addr, rs1_enable, rs2_enable,
               rd_addr, rd_enable, is_load, use_fpu, flush,
        output stall, issue, fpu_busy, pending
    );
endinterface

// File: rtl/hazard_unit.sv
// Per-register scoreboard interlock: stalls issue on RAW, WAW-reorder and busy-FPU hazards.
// stall/issue are combinational from state and inputs; scoreboard updates one edge later; flush beats stall.
module hazard_unit #(
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int FPU_READY  = 3,
    parameter int FPU_BUSY   = 2,
    parameter int CNT_W      = 3
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);
    localparam logic [CNT_W-1:0] ALU_LAT  = CNT_W'(ALU_READY);
    localparam logic [CNT_W-1:0] LOAD_LAT = CNT_W'(LOAD_READY);
    localparam logic [CNT_W-1:0] FPU_LAT  = CNT_W'(FPU_READY);
    localparam logic [CNT_W-1:0] FPU_OCC  = CNT_W'(FPU_BUSY);

    // Entry 0 exists only to keep indexing simple; it is held at zero.
    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]       fpu_cnt_q, fpu_cnt_d;
    logic [4:0]             last_rd_q, last_rd_d;
    logic                   last_wr_q, last_wr_d;
    logic                   last_fpu_q, last_fpu_d;

    logic [CNT_W-1:0] lat;
    logic             raw, waw, strc, hazard, stall, issue, writes_rd;
    logic [31:0]      pending;

    always_comb begin
        lat = hz.is_load ? LOAD_LAT : (hz.use_fpu ? FPU_LAT : ALU_LAT);
        raw = (hz.rs1_enable && hz.rs1_addr != 5'd0 && cnt_q[hz.rs1_addr] != '0) ||
              (hz.rs2_enable && hz.rs2_addr != 5'd0 && cnt_q[hz.rs2_addr] != '0);
        waw = hz.rd_enable && hz.rd_addr != 5'd0 && cnt_q[hz.rd_addr] > lat;
        strc = hz.use_fpu && fpu_cnt_q != '0;
        hazard = raw || waw || strc;
        stall = !rst && hz.issue_valid && !hz.flush && hazard;
        issue = !rst && hz.issue_valid && !hz.flush && !hazard;
        writes_rd = hz.rd_enable && hz.rd_addr != 5'd0;

        pending = '0;
        for (int r = 1; r < 32; r++) begin
            pending[r] = cnt_q[r] != '0;
        end
    end

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
        end
        fpu_cnt_d = (fpu_cnt_q != '0) ? fpu_cnt_q - 1'b1 : '0;

        if (issue && writes_rd) begin
            cnt_d[hz.rd_addr] = lat;
        end
        if (issue && hz.use_fpu) begin
            fpu_cnt_d = FPU_OCC;
        end
        // Retire whatever the flushed instruction had reserved.
        if (hz.flush && last_wr_q) begin
            cnt_d[last_rd_q] = '0;
        end
        if (hz.flush && last_fpu_q) begin
            fpu_cnt_d = '0;
        end
        cnt_d[0] = '0;

        last_rd_d  = hz.rd_addr;
        last_wr_d  = issue && writes_rd;
        last_fpu_d = issue && hz.use_fpu;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            fpu_cnt_q  <= '0;
            last_rd_q  <= '0;
            last_wr_q  <= 1'b0;
            last_fpu_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            fpu_cnt_q  <= fpu_cnt_d;
            last_rd_q  <= last_rd_d;
            last_wr_q  <= last_wr_d;
            last_fpu_q <= last_fpu_d;
        end
    end

    assign hz.stall    = stall;
    assign hz.issue    = issue;
    assign hz.fpu_busy = fpu_cnt_q != '0;
    assign hz.pending  = pending;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a timestamp-based reference model.
module tb_hazard_unit;
    localparam int ALU_READY  = 1;
    localparam int LOAD_READY = 2;
    localparam int FPU_READY  = 3;
    localparam int FPU_BUSY   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hazard_unit_if hif ();

    hazard_unit #(
        .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY), .FPU_READY(FPU_READY),
        .FPU_BUSY(FPU_BUSY), .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hif)
    );

    always #5 clk = ~clk;

    // Model: each register remembers the cycle at which its result becomes forwardable.
    int ready_at [32];
    int fpu_free;
    int t;
    bit m_last_wr, m_last_fpu;
    int m_last_rd;
    bit seen_issue;
    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, t);
    endtask

    task automatic cyc(input bit v, input int a1, input bit e1, input int a2, input bit e2,
                       input int d, input bit de, input bit ld, input bit fp,
                       input bit fl, input bit r, input bit chk_state);
        int lat;
        bit raw, waw, st, e_stall, e_issue, e_busy;
        logic [31:0] e_pend;
        @(negedge clk);
        rst = r;
        hif.issue_valid = v;
        hif.rs1_addr = 5'(a1); hif.rs1_enable = e1;
        hif.rs2_addr = 5'(a2); hif.rs2_enable = e2;
        hif.rd_addr  = 5'(d);  hif.rd_enable  = de;
        hif.is_load = ld; hif.use_fpu = fp; hif.flush = fl;
        #1;
        lat = ld ? LOAD_READY : (fp ? FPU_READY : ALU_READY);
        raw = (e1 && a1 != 0 && ready_at[a1] > t) || (e2 && a2 != 0 && ready_at[a2] > t);
        waw = de && d != 0 && (ready_at[d] - t) > lat;
        st  = fp && fpu_free > t;
        e_stall = !r && v && !fl && (raw || waw || st);
        e_issue = !r && v && !fl && !(raw || waw || st);
        e_pend = '0;
        for (int i = 1; i < 32; i++) e_pend[i] = ready_at[i] > t;
        e_busy = fpu_free > t;

        chk("stall", {31'b0, hif.stall}, {31'b0, e_stall});
        chk("issue", {31'b0, hif.issue}, {31'b0, e_issue});
        if (chk_state) begin
            chk("pending", hif.pending, e_pend);
            chk("fpu_busy", {31'b0, hif.fpu_busy}, {31'b0, e_busy});
        end
        seen_issue = hif.issue;

        if (r) begin
            for (int i = 0; i < 32; i++) ready_at[i] = 0;
            fpu_free = 0;
            m_last_wr = 0;
            m_last_fpu = 0;
        end else begin
            if (e_issue && de && d != 0) ready_at[d] = t + 1 + lat;
            if (e_issue && fp) fpu_free = t + 1 + FPU_BUSY;
            if (fl && m_last_wr) ready_at[m_last_rd] = t + 1;
            if (fl && m_last_fpu) fpu_free = t + 1;
            m_last_wr = e_issue && de && d != 0;
            m_last_fpu = e_issue && fp;
            m_last_rd = d;
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Presents one instruction until it issues (bounded) and returns the stall cycle count.
    task automatic hold(input int a1, input bit e1, input int a2, input bit e2,
                        input int d, input bit de, input bit ld, input bit fp, output int n);
        n = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1, a1, e1, a2, e2, d, de, ld, fp, 0, 0, 1);
            if (seen_issue) break;
            n++;
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        fpu_free = 0; t = 0; m_last_wr = 0; m_last_fpu = 0; m_last_rd = 0;

        // Reset: state is unknown before the first edge, so only stall/issue are checked there.
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
        idle(1);

        // Load r3, dependent add r4 = r3 + r1.
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 1);
        hold(3, 1, 1, 1, 4, 1, 0, 0, n);
        chk("load_use_stalls", n, LOAD_READY);
        idle(4);

        // Independent ALU ops.
        cyc(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 1);
        hold(1, 1, 2, 1, 6, 1, 0, 0, n);
        chk("indep_stalls", n, 0);
        idle(4);

        // Back-to-back FPU ops, disjoint registers.
        cyc(1, 1, 1, 2, 1, 10, 1, 0, 1, 0, 0, 1);
        hold(11, 1, 12, 1, 13, 1, 0, 1, n);
        chk("fpu_struct_stalls", n, FPU_BUSY);
        idle(5);

        // WAW: FPU writes r7, then ALU writes r7.
        cyc(1, 1, 1, 0, 0, 7, 1, 0, 1, 0, 0, 1);
        hold(2, 1, 0, 0, 7, 1, 0, 0, n);
        chk("waw_stalls", n, FPU_READY - ALU_READY);
        idle(5);

        // Flush kills the load r8 and clears its reservation.
        cyc(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 1);
        cyc(1, 8, 1, 0, 0, 12, 1, 0, 0, 1, 0, 1);
        hold(8, 1, 0, 0, 12, 1, 0, 0, n);
        chk("post_flush_stalls", n, 0);
        idle(3);

        // Reset while a consumer of r9 is stalled.
        cyc(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1);
        cyc(1, 9, 1, 0, 0, 14, 1, 0, 0, 0, 0, 1);
        cyc(1, 9, 1, 0, 0, 14, 1, 0, 0, 0, 1, 1);
        hold(9, 1, 0, 0, 14, 1, 0, 0, n);
        chk("post_reset_stalls", n, 0);
        idle(3);

        // Random traffic over a small register window to provoke frequent hazards.
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom % 4) != 0,
                $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2,
                $urandom % 8, ($urandom % 4) != 0,
                ($urandom % 4) == 0, ($urandom % 3) == 0,
                ($urandom % 8) == 0, ($urandom % 64) == 0, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
